line_clear: RTL
===============

Name: line_clear

Overview:
- Reads back the board RAM that the piece-locking path writes.
- Scans every row from bottom to top, detects full rows and removes them: rows above shift down one, and the top row is zero-filled.
- Invoked by the game controller after a piece is written to RAM and before the board is redrawn.
- Uses the same enable/complete module-select handshake as the other board modules.

Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- CW, 6, colour width (0 = empty cell)
- AW, 8, board RAM address width (address = row*COLS + col)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  module select; a rising request starts a pass
- ram_q  in  CW  board RAM read data, valid the cycle after ram_addr is presented
- ram_addr  out  AW  board RAM address
- wren  out  1  board RAM write enable
- data  out  CW  board RAM write data
- busy  out  1  high while a pass is in progress (SCAN_RD through CLR_TOP)
- complete  out  1  one-cycle pulse when the pass finishes
- lines_cleared  out  3  rows removed in the last pass, saturating at 7

Behaviour:
- Reset (async, any state): state=IDLE; ram_addr=0, wren=0, data=0, busy=0, complete=0, lines_cleared=0. Partially shifted RAM is not restored; the controller must clear the board.
- Registers:
  - y = row under test
  - x = column
  - base = y*COLS, maintained by add/subtract of COLS (no multiplier)
  - d = destination row during a shift
- RAM read latency is 1 cycle; address widths are AW and all arithmetic is unsigned.
- States and transitions:
  - IDLE:
    - If enable=1: y=ROWS-1, x=0, lines_cleared=0 → SCAN_RD.
  - SCAN_RD:
    - ram_addr=base+x → SCAN_CHK.
  - SCAN_CHK (ram_q valid):
    - If ram_q==0 (row not full): if y==0 → DONE; else y-1, x=0 → SCAN_RD.
    - Else if x==COLS-1 (row full): lines_cleared+1 (saturating); d=y, x=0 → COPY_RD, or → CLR_TOP directly if y==0.
    - Else: x+1 → SCAN_RD.
  - COPY_RD:
    - ram_addr=(d-1)*COLS+x → COPY_WR.
  - COPY_WR:
    - wren=1, ram_addr=d*COLS+x, data=ram_q.
    - If x<COLS-1: x+1 → COPY_RD.
    - Else if d==1: x=0 → CLR_TOP.
    - Else: d-1, x=0 → COPY_RD.
  - CLR_TOP:
    - wren=1, ram_addr=x, data=0, one cell per cycle.
    - After x==COLS-1: x=0 and y is unchanged, so the same row is rescanned → SCAN_RD.
  - DONE:
    - complete=1 for exactly one cycle → HOLD.
  - HOLD:
    - Stay while enable=1; → IDLE when enable=0. Holding enable high never retriggers a pass.
- wren is 0 in every state except COPY_WR and CLR_TOP.
- Latency:
  - Empty board: complete is high 1+2*ROWS cycles after the IDLE edge that sees enable (41 at defaults).
  - Each cleared row at index r adds 2*COLS + 2*COLS*r + COLS cycles before its rescan.
- Boundary conditions:
  - Full row at y=0: no copies; only CLR_TOP, then rescan.
  - Consecutive full rows: rescanning the same y catches the next full row shifted into place.
  - Whole board full: terminates after ROWS clears, since zero rows enter from the top; lines_cleared saturates at 7.
- enable dropping mid-pass is ignored; the pass completes and complete still pulses.
- lines_cleared holds its value from DONE until the next pass starts.

Decomposition:
- Shared package tetris_pkg:
  - BOARD_COLS, BOARD_ROWS, COLOUR_W, BOARD_AW
  - EMPTY_CELL=0
  - State encoding localparams for this block
- Single module; no sub-module is natural. The base/row-offset arithmetic stays inline.

Test Plan:
- All-zero RAM, enable pulse → complete at cycle 41, wren never asserted, lines_cleared=0.
- Row 19 all colour 3, row 18 col 4=colour 5, rest 0 → after complete: row 19 col 4=5, all else 0, lines_cleared=1.
- Rows 18 and 19 full, row 17 col 0=colour 2 → row 19 col 0=2, rows 0..18 empty, lines_cleared=2, one complete pulse.
- Only row 0 full → exactly 10 wren cycles, all data=0 at addresses 0..9, lines_cleared=1.
- Assert reset during COPY_WR of the second case → all outputs 0 immediately, state IDLE; next enable starts a fresh scan from row 19.
- enable held high for 200 cycles on an empty board → exactly one complete pulse, busy low after DONE, no second scan.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry and the line_clear state encoding used across the
// Tetris board modules.
package tetris_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int COLOUR_W   = 6;
  localparam int BOARD_AW   = 8;
  localparam int EMPTY_CELL = 0;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_SCAN_RD,
    LC_SCAN_CHK,
    LC_COPY_RD,
    LC_COPY_WR,
    LC_CLR_TOP,
    LC_DONE,
    LC_HOLD
  } lc_state_t;

endpackage

// File: rtl/line_clear.sv
// Scans the board RAM bottom-up, removes full rows by shifting everything
// above down one row and zero-filling the top row, then pulses complete.
module line_clear
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS,
  parameter int CW   = COLOUR_W,
  parameter int AW   = BOARD_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] ram_q,
  output logic [AW-1:0] ram_addr,
  output logic          wren,
  output logic [CW-1:0] data,
  output logic          busy,
  output logic          complete,
  output logic [2:0]    lines_cleared
);

  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] LAST_X   = AW'(COLS - 1);
  localparam logic [AW-1:0] TOP_Y    = AW'(ROWS - 1);
  localparam logic [AW-1:0] TOP_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] ONE      = AW'(1);

  lc_state_t     state, state_n;
  logic [AW-1:0] y, y_n, x, x_n, base, base_n, d, d_n, dbase, dbase_n;
  logic [2:0]    lc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LC_IDLE;
      y             <= '0;
      x             <= '0;
      base          <= '0;
      d             <= '0;
      dbase         <= '0;
      lines_cleared <= '0;
    end else begin
      state         <= state_n;
      y             <= y_n;
      x             <= x_n;
      base          <= base_n;
      d             <= d_n;
      dbase         <= dbase_n;
      lines_cleared <= lc_n;
    end
  end

  // base tracks y*COLS and dbase tracks d*COLS so no multiplier is needed
  always_comb begin
    state_n  = state;
    y_n      = y;
    x_n      = x;
    base_n   = base;
    d_n      = d;
    dbase_n  = dbase;
    lc_n     = lines_cleared;
    ram_addr = '0;
    wren     = 1'b0;
    data     = '0;
    busy     = 1'b0;
    complete = 1'b0;
    case (state)
      LC_IDLE: begin
        if (enable) begin
          y_n     = TOP_Y;
          base_n  = TOP_BASE;
          x_n     = '0;
          lc_n    = '0;
          state_n = LC_SCAN_RD;
        end
      end
      LC_SCAN_RD: begin
        busy     = 1'b1;
        ram_addr = base + x;
        state_n  = LC_SCAN_CHK;
      end
      LC_SCAN_CHK: begin
        busy = 1'b1;
        if (ram_q == CW'(EMPTY_CELL)) begin
          if (y == '0) begin
            state_n = LC_DONE;
          end else begin
            y_n     = y - ONE;
            base_n  = base - COLS_A;
            x_n     = '0;
            state_n = LC_SCAN_RD;
          end
        end else if (x == LAST_X) begin
          lc_n    = (lines_cleared == 3'd7) ? lines_cleared : lines_cleared + 3'd1;
          d_n     = y;
          dbase_n = base;
          x_n     = '0;
          state_n = (y == '0) ? LC_CLR_TOP : LC_COPY_RD;
        end else begin
          x_n     = x + ONE;
          state_n = LC_SCAN_RD;
        end
      end
      LC_COPY_RD: begin
        busy     = 1'b1;
        ram_addr = dbase - COLS_A + x;
        state_n  = LC_COPY_WR;
      end
      LC_COPY_WR: begin
        busy     = 1'b1;
        wren     = 1'b1;
        ram_addr = dbase + x;
        data     = ram_q;
        if (x != LAST_X) begin
          x_n     = x + ONE;
          state_n = LC_COPY_RD;
        end else if (d == ONE) begin
          x_n     = '0;
          state_n = LC_CLR_TOP;
        end else begin
          d_n     = d - ONE;
          dbase_n = dbase - COLS_A;
          x_n     = '0;
          state_n = LC_COPY_RD;
        end
      end
      LC_CLR_TOP: begin
        busy     = 1'b1;
        wren     = 1'b1;
        ram_addr = x;
        data     = CW'(EMPTY_CELL);
        if (x == LAST_X) begin
          // y is left alone so the row that just dropped in gets rescanned
          x_n     = '0;
          state_n = LC_SCAN_RD;
        end else begin
          x_n = x + ONE;
        end
      end
      LC_DONE: begin
        complete = 1'b1;
        state_n  = LC_HOLD;
      end
      LC_HOLD: begin
        if (!enable) state_n = LC_IDLE;
      end
      default: state_n = LC_IDLE;
    endcase
  end

endmodule
